// File: rtl/snn_pkg.sv
// Shared types and constants for the spiking-neuron timestep sequencer.
package snn_pkg;

  localparam int ACC_WEIGHT_LANES = 4;
  localparam int DATA_W_DEFAULT   = 32;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_READ = 3'd1,
    ST_LOAD = 3'd2,
    ST_EXEC = 3'd3,
    ST_WB   = 3'd4,
    ST_DONE = 3'd5
  } seq_state_e;

endpackage

// File: rtl/spike_event_fifo.sv
// Synchronous spike-event FIFO: push/push_ok on the write side, valid/ready on the read side.
// A full FIFO still accepts a push in a cycle where its head is being popped.
module spike_event_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_data,
  output logic         push_ok,
  output logic         valid,
  output logic [W-1:0] head,
  input  logic         pop_ready
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PW = AW + 1;

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic          empty_s, full_s, pop_fire_s, push_fire_s;

  // Wrap bit distinguishes full from empty when the index bits match.
  assign empty_s     = (wr_ptr_q == rd_ptr_q);
  assign full_s      = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop_fire_s  = !empty_s && pop_ready;
  assign push_ok     = !full_s || pop_fire_s;
  assign push_fire_s = push && push_ok;
  assign valid       = !empty_s;
  assign head        = empty_s ? {W{1'b0}} : mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    mem_d    = mem_q;
    if (push_fire_s) begin
      mem_d[wr_ptr_q[AW-1:0]] = push_data;
      wr_ptr_d = wr_ptr_q + PW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_fire_s) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= {PW{1'b0}};
      rd_ptr_q <= {PW{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {W{1'b0}};
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: rtl/neuron_update_sequencer.sv
// Timestep sequencer for the LIF accelerator: reads each neuron, drives the accelerator,
// writes the new potential back and queues spike events for the router.
module neuron_update_sequencer
  import snn_pkg::*;
#(
  parameter int NEURON_COUNT = 16,
  parameter int ID_W         = $clog2(NEURON_COUNT),
  parameter int DATA_W       = DATA_W_DEFAULT,
  parameter int WEIGHT_W     = ACC_WEIGHT_LANES * DATA_W,
  parameter int ACC_LATENCY  = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                        CLK,
  input  logic                        RESET_N,
  input  logic                        start,
  input  logic [ACC_WEIGHT_LANES-1:0] spike_in_vec,
  output logic                        busy,
  output logic                        done,
  output logic                        mem_rd_en,
  output logic [ID_W-1:0]             mem_addr,
  input  logic [DATA_W-1:0]           mem_rd_potential,
  input  logic [DATA_W-1:0]           mem_rd_threshold,
  input  logic [2:0]                  mem_rd_decay,
  input  logic [WEIGHT_W-1:0]         mem_rd_weight,
  output logic [ACC_WEIGHT_LANES-1:0] acc_spike_in,
  output logic [WEIGHT_W-1:0]         acc_weight,
  output logic [DATA_W-1:0]           acc_v_threshold,
  output logic [DATA_W-1:0]           acc_current_potential,
  output logic [2:0]                  acc_decay_rate,
  input  logic                        acc_spiked,
  input  logic [DATA_W-1:0]           acc_potential,
  output logic                        mem_wr_en,
  output logic [ID_W-1:0]             mem_wr_addr,
  output logic [DATA_W-1:0]           mem_wr_data,
  output logic                        spk_valid,
  output logic [ID_W-1:0]             spk_id,
  input  logic                        spk_ready
);

  localparam int LAT_W = (ACC_LATENCY > 1) ? $clog2(ACC_LATENCY) : 1;

  seq_state_e                  state_q, state_d;
  logic [ID_W-1:0]             cnt_q, cnt_d;
  logic [LAT_W-1:0]            exec_q, exec_d;
  logic                        busy_q, busy_d;
  logic                        done_q, done_d;
  logic                        rd_en_q, rd_en_d;
  logic [ID_W-1:0]             addr_q, addr_d;
  logic [ACC_WEIGHT_LANES-1:0] spike_q, spike_d;
  logic [WEIGHT_W-1:0]         weight_q, weight_d;
  logic [DATA_W-1:0]           thr_q, thr_d;
  logic [DATA_W-1:0]           pot_q, pot_d;
  logic [2:0]                  decay_q, decay_d;
  logic                        wr_en_q, wr_en_d;
  logic [ID_W-1:0]             wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0]           wr_data_q, wr_data_d;
  logic                        push_s, push_ok_s, cnt_last_s;

  assign cnt_last_s = (cnt_q == ID_W'(NEURON_COUNT - 1));

  spike_event_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (ID_W)
  ) u_fifo (
    .clk       (CLK),
    .rst_n     (RESET_N),
    .push      (push_s),
    .push_data (cnt_q),
    .push_ok   (push_ok_s),
    .valid     (spk_valid),
    .head      (spk_id),
    .pop_ready (spk_ready)
  );

  // Next-state and registered-output values; every output flop is loaded from its _d here.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    exec_d    = exec_q;
    done_d    = 1'b0;
    rd_en_d   = 1'b0;
    addr_d    = addr_q;
    spike_d   = spike_q;
    weight_d  = weight_q;
    thr_d     = thr_q;
    pot_d     = pot_q;
    decay_d   = decay_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    push_s    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_READ;
          spike_d = spike_in_vec;
          rd_en_d = 1'b1;
          addr_d  = cnt_q;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_READ: state_d = ST_LOAD;
      ST_LOAD: begin
        state_d  = ST_EXEC;
        exec_d   = {LAT_W{1'b0}};
        weight_d = mem_rd_weight;
        thr_d    = mem_rd_threshold;
        pot_d    = mem_rd_potential;
        decay_d  = mem_rd_decay;
      end
      ST_EXEC: begin
        if (exec_q == LAT_W'(ACC_LATENCY - 1)) begin
          state_d = ST_WB;
        end else begin
          exec_d = exec_q + LAT_W'(1);
        end
      end
      ST_WB: begin
        // A spike that cannot enter the FIFO holds the neuron in WB without writing back.
        if (acc_spiked && !push_ok_s) begin
          state_d = ST_WB;
        end else begin
          wr_en_d   = 1'b1;
          wr_addr_d = cnt_q;
          wr_data_d = acc_potential;
          push_s    = acc_spiked;
          if (cnt_last_s) begin
            cnt_d   = {ID_W{1'b0}};
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            cnt_d   = cnt_q + ID_W'(1);
            state_d = ST_READ;
            rd_en_d = 1'b1;
            addr_d  = cnt_q + ID_W'(1);
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers; reset aborts any sweep in flight.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q   <= ST_IDLE;
      cnt_q     <= {ID_W{1'b0}};
      exec_q    <= {LAT_W{1'b0}};
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      rd_en_q   <= 1'b0;
      addr_q    <= {ID_W{1'b0}};
      spike_q   <= {ACC_WEIGHT_LANES{1'b0}};
      weight_q  <= {WEIGHT_W{1'b0}};
      thr_q     <= {DATA_W{1'b0}};
      pot_q     <= {DATA_W{1'b0}};
      decay_q   <= 3'd0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= {ID_W{1'b0}};
      wr_data_q <= {DATA_W{1'b0}};
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      exec_q    <= exec_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      rd_en_q   <= rd_en_d;
      addr_q    <= addr_d;
      spike_q   <= spike_d;
      weight_q  <= weight_d;
      thr_q     <= thr_d;
      pot_q     <= pot_d;
      decay_q   <= decay_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign busy                  = busy_q;
  assign done                  = done_q;
  assign mem_rd_en             = rd_en_q;
  assign mem_addr              = addr_q;
  assign acc_spike_in          = spike_q;
  assign acc_weight            = weight_q;
  assign acc_v_threshold       = thr_q;
  assign acc_current_potential = pot_q;
  assign acc_decay_rate        = decay_q;
  assign mem_wr_en             = wr_en_q;
  assign mem_wr_addr           = wr_addr_q;
  assign mem_wr_data           = wr_data_q;

endmodule

// File: tb/tb_neuron_update_sequencer.sv
// Bench for neuron_update_sequencer: memory and accelerator models, table-driven sweeps,
// reset/stall corner sequences and randomized sweeps checked against a reference model.
module tb_neuron_update_sequencer;

  localparam int N = 16;

  logic         CLK, RESET_N, start;
  logic [3:0]   spike_in_vec;
  logic         busy, done, mem_rd_en;
  logic [3:0]   mem_addr;
  logic [31:0]  mem_rd_potential, mem_rd_threshold;
  logic [2:0]   mem_rd_decay;
  logic [127:0] mem_rd_weight;
  logic [3:0]   acc_spike_in;
  logic [127:0] acc_weight;
  logic [31:0]  acc_v_threshold, acc_current_potential;
  logic [2:0]   acc_decay_rate;
  logic         acc_spiked;
  logic [31:0]  acc_potential;
  logic         mem_wr_en;
  logic [3:0]   mem_wr_addr;
  logic [31:0]  mem_wr_data;
  logic         spk_valid;
  logic [3:0]   spk_id;
  logic         spk_ready;

  neuron_update_sequencer dut (
    .CLK(CLK), .RESET_N(RESET_N), .start(start), .spike_in_vec(spike_in_vec),
    .busy(busy), .done(done), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
    .mem_rd_potential(mem_rd_potential), .mem_rd_threshold(mem_rd_threshold),
    .mem_rd_decay(mem_rd_decay), .mem_rd_weight(mem_rd_weight),
    .acc_spike_in(acc_spike_in), .acc_weight(acc_weight), .acc_v_threshold(acc_v_threshold),
    .acc_current_potential(acc_current_potential), .acc_decay_rate(acc_decay_rate),
    .acc_spiked(acc_spiked), .acc_potential(acc_potential),
    .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
    .spk_valid(spk_valid), .spk_id(spk_id), .spk_ready(spk_ready)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic [31:0]  m_pot [N];
  logic [31:0]  m_thr [N];
  logic [2:0]   m_dec [N];
  logic [127:0] m_wgt [N];

  function automatic logic [31:0] acc_sum(input logic [3:0] v, input logic [127:0] w);
    logic [31:0] s;
    s = 32'd0;
    for (int i = 0; i < 4; i++) if (v[i]) s = s + w[32*i +: 32];
    return s;
  endfunction

  // Neuron memory: one-cycle read latency.
  always @(posedge CLK) begin
    if (mem_rd_en) begin
      mem_rd_potential <= m_pot[mem_addr];
      mem_rd_threshold <= m_thr[mem_addr];
      mem_rd_decay     <= m_dec[mem_addr];
      mem_rd_weight    <= m_wgt[mem_addr];
    end
  end

  // Accelerator with one cycle of latency.
  always @(posedge CLK) begin
    acc_potential <= acc_current_potential + acc_sum(acc_spike_in, acc_weight);
    acc_spiked    <= (acc_current_potential + acc_sum(acc_spike_in, acc_weight)) >= acc_v_threshold;
  end

  logic [3:0]  obs_wr_addr[$], obs_evt[$], exp_wr_addr[$], exp_evt[$];
  logic [31:0] obs_wr_data[$], exp_wr_data[$];
  int wr_base, evt_base;

  always @(negedge CLK) begin
    if (RESET_N && mem_wr_en) begin
      obs_wr_addr.push_back(mem_wr_addr);
      obs_wr_data.push_back(mem_wr_data);
    end
    if (RESET_N && spk_valid && spk_ready) obs_evt.push_back(spk_id);
  end

  logic [247:0] all_outs;
  assign all_outs = {busy, done, mem_rd_en, mem_addr, acc_spike_in, acc_weight, acc_v_threshold,
                     acc_current_potential, acc_decay_rate, mem_wr_en, mem_wr_addr, mem_wr_data,
                     spk_valid, spk_id};

  int errors, checks;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic model_sweep(input logic [3:0] v);
    logic [31:0] p;
    for (int n = 0; n < N; n++) begin
      p = m_pot[n] + acc_sum(v, m_wgt[n]);
      exp_wr_addr.push_back(4'(n));
      exp_wr_data.push_back(p);
      if (p >= m_thr[n]) exp_evt.push_back(4'(n));
    end
  endtask

  task automatic start_sweep(input logic [3:0] v);
    spike_in_vec = v;
    start = 1'b1;
    @(posedge CLK); #1;
    start = 1'b0;
    spike_in_vec = 4'($urandom);
  endtask

  // k counts clock edges after the start edge; done/busy seen at negedge k hold across edge k.
  task automatic run_until_done(input int budget, input bit rnd_rdy, input bit pulse_start,
                                output int dcyc, output int dcnt, output bit busy_ok);
    dcyc = 0; dcnt = 0; busy_ok = 1'b1;
    for (int k = 1; k <= budget; k++) begin
      @(negedge CLK);
      if (done) begin
        dcnt++;
        if (dcyc == 0) dcyc = k;
      end
      if (k == 1 && !busy) busy_ok = 1'b0;
      if (done && !busy) busy_ok = 1'b0;
      if (dcyc != 0 && k > dcyc && busy) busy_ok = 1'b0;
      @(posedge CLK); #1;
      start = pulse_start && (k == 10 || k == 40 || k == 64);
      if (rnd_rdy) spk_ready = 1'($urandom_range(0, 1));
      if (dcyc != 0 && k >= dcyc + 3) break;
    end
    start = 1'b0;
    spk_ready = 1'b1;
  endtask

  task automatic check_writes(input string nm);
    int n;
    n = obs_wr_addr.size() - wr_base;
    chk({nm, "_wr_count"}, n, exp_wr_addr.size());
    for (int i = 0; i < exp_wr_addr.size() && i < n; i++)
      chk($sformatf("%s_wr%0d", nm, i), {obs_wr_addr[wr_base+i], obs_wr_data[wr_base+i]},
          {exp_wr_addr[i], exp_wr_data[i]});
    wr_base = obs_wr_addr.size();
    exp_wr_addr.delete();
    exp_wr_data.delete();
  endtask

  task automatic check_events(input string nm);
    int n;
    spk_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (!spk_valid && (obs_evt.size() - evt_base) >= exp_evt.size()) break;
      @(posedge CLK); #1;
    end
    n = obs_evt.size() - evt_base;
    chk({nm, "_evt_count"}, n, exp_evt.size());
    chk({nm, "_fifo_empty"}, spk_valid, 1'b0);
    for (int i = 0; i < exp_evt.size() && i < n; i++)
      chk($sformatf("%s_evt%0d", nm, i), obs_evt[evt_base+i], exp_evt[i]);
    evt_base = obs_evt.size();
    exp_evt.delete();
  endtask

  typedef struct {
    logic [3:0]   vec;
    logic [31:0]  pot;
    logic [31:0]  thr;
    logic [127:0] wgt;
    logic [31:0]  exp_wr;
    bit           exp_spk;
    int           exp_done;
    bit           pulse;
  } row_t;

  row_t tbl [5];

  initial begin
    int  dcyc, dcnt;
    bit  bok;
    logic [3:0] v;

    tbl[0] = '{vec:4'b0000, pot:32'd20, thr:32'd78, wgt:{4{32'd64}},
               exp_wr:32'd20, exp_spk:1'b0, exp_done:65, pulse:1'b1};
    tbl[1] = '{vec:4'b0001, pot:32'd20, thr:32'd78, wgt:{32'd7, 32'd7, 32'd7, 32'd64},
               exp_wr:32'd84, exp_spk:1'b1, exp_done:65, pulse:1'b0};
    tbl[2] = '{vec:4'b1010, pot:32'd5, thr:32'd60, wgt:{32'd40, 32'd30, 32'd20, 32'd10},
               exp_wr:32'd65, exp_spk:1'b1, exp_done:65, pulse:1'b1};
    tbl[3] = '{vec:4'b1111, pot:32'd100, thr:32'd111, wgt:{32'd4, 32'd3, 32'd2, 32'd1},
               exp_wr:32'd110, exp_spk:1'b0, exp_done:65, pulse:1'b0};
    tbl[4] = '{vec:4'b0100, pot:32'd28, thr:32'd78, wgt:{32'd0, 32'd50, 32'd0, 32'd0},
               exp_wr:32'd78, exp_spk:1'b1, exp_done:65, pulse:1'b0};

    errors = 0; checks = 0; wr_base = 0; evt_base = 0;
    RESET_N = 1'b0; start = 1'b0; spike_in_vec = 4'd0; spk_ready = 1'b1;
    repeat (3) @(posedge CLK);
    #1 chk("reset_outputs", all_outs, 248'd0);
    @(negedge CLK) RESET_N = 1'b1;
    @(posedge CLK); #1;

    for (int r = 0; r < 5; r++) begin
      for (int n = 0; n < N; n++) begin
        m_pot[n] = tbl[r].pot; m_thr[n] = tbl[r].thr; m_wgt[n] = tbl[r].wgt;
        m_dec[n] = 3'($urandom_range(0, 7));
        exp_wr_addr.push_back(4'(n));
        exp_wr_data.push_back(tbl[r].exp_wr);
        if (tbl[r].exp_spk) exp_evt.push_back(4'(n));
      end
      start_sweep(tbl[r].vec);
      run_until_done(200, 1'b0, tbl[r].pulse, dcyc, dcnt, bok);
      chk($sformatf("row%0d_done_cycle", r), dcyc, tbl[r].exp_done);
      chk($sformatf("row%0d_done_pulses", r), dcnt, 1);
      chk($sformatf("row%0d_busy_window", r), bok, 1'b1);
      chk($sformatf("row%0d_spike_latch", r), acc_spike_in, tbl[r].vec);
      check_writes($sformatf("row%0d", r));
      check_events($sformatf("row%0d", r));
    end

    // Reset while neuron 5 is in EXEC, with three events still queued.
    for (int n = 0; n < N; n++) begin
      m_pot[n] = 32'd20 + 32'(n);
      m_thr[n] = (n < 3) ? 32'd10 : 32'd1000;
      m_dec[n] = 3'(n);
      m_wgt[n] = {32'(n), 32'(n), 32'(n), 32'd64};
    end
    spk_ready = 1'b0;
    start_sweep(4'b0001);
    repeat (22) @(posedge CLK);
    #2;
    chk("exec_n5_operands", {acc_weight, acc_v_threshold, acc_current_potential, acc_decay_rate},
        {m_wgt[5], m_thr[5], m_pot[5], m_dec[5]});
    chk("exec_n5_valid", spk_valid, 1'b1);
    RESET_N = 1'b0;
    #1 chk("rst_async_outputs", all_outs, 248'd0);
    @(negedge CLK);
    chk("rst_hold_outputs", all_outs, 248'd0);
    @(posedge CLK);
    @(negedge CLK) RESET_N = 1'b1;
    repeat (4) @(posedge CLK);
    #1;
    chk("rst_fifo_empty", spk_valid, 1'b0);
    chk("rst_idle", busy, 1'b0);
    chk("rst_wr_count", obs_wr_addr.size() - wr_base, 5);
    wr_base = obs_wr_addr.size();
    evt_base = obs_evt.size();
    spk_ready = 1'b1;

    // Backpressure: stall at neuron 4, then a full FIFO popped and pushed in one cycle.
    for (int n = 0; n < N; n++) begin
      m_pot[n] = 32'd20; m_thr[n] = 32'd78; m_dec[n] = 3'd3;
      m_wgt[n] = {32'd9, 32'd9, 32'd9, 32'd64};
    end
    model_sweep(4'b0001);
    spk_ready = 1'b0;
    start_sweep(4'b0001);
    repeat (40) @(posedge CLK);
    #1;
    chk("stall_wr_count", obs_wr_addr.size() - wr_base, 4);
    chk("stall_busy", busy, 1'b1);
    chk("stall_head", {spk_valid, spk_id}, {1'b1, 4'd0});
    chk("stall_no_write", mem_wr_en, 1'b0);
    spk_ready = 1'b1;
    @(posedge CLK); #1;
    spk_ready = 1'b0;
    chk("poppush_write", {mem_wr_en, mem_wr_addr, mem_wr_data}, {1'b1, 4'd4, 32'd84});
    chk("poppush_head", {spk_valid, spk_id}, {1'b1, 4'd1});
    repeat (20) @(posedge CLK);
    #1;
    chk("poppush_full_again", obs_wr_addr.size() - wr_base, 5);
    chk("poppush_head_held", {spk_valid, spk_id, busy}, {1'b1, 4'd1, 1'b1});
    spk_ready = 1'b1;
    run_until_done(200, 1'b0, 1'b0, dcyc, dcnt, bok);
    chk("stall_done_pulses", dcnt, 1);
    check_writes("stall");
    check_events("stall");

    // Randomized sweeps with random backpressure.
    for (int s = 0; s < 4; s++) begin
      for (int n = 0; n < N; n++) begin
        m_pot[n] = 32'($urandom_range(0, 200));
        m_thr[n] = 32'($urandom_range(50, 400));
        m_dec[n] = 3'($urandom_range(0, 7));
        m_wgt[n] = {32'($urandom_range(0, 100)), 32'($urandom_range(0, 100)),
                    32'($urandom_range(0, 100)), 32'($urandom_range(0, 100))};
      end
      v = 4'($urandom);
      model_sweep(v);
      start_sweep(v);
      run_until_done(800, 1'b1, 1'b0, dcyc, dcnt, bok);
      chk($sformatf("rnd%0d_done_pulses", s), dcnt, 1);
      chk($sformatf("rnd%0d_busy_window", s), bok, 1'b1);
      chk($sformatf("rnd%0d_spike_latch", s), acc_spike_in, v);
      check_writes($sformatf("rnd%0d", s));
      check_events($sformatf("rnd%0d", s));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
